// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving the combinational ALU and register file for single and two-step ops.
// Optional build macro ALU_SEQ_CP_NOWB_EN: SINGLE CP/TM/TCM update flags only, no register write.
module alu_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [4:0] mode,
   input  logic [7:0] addr,
   input  logic [7:0] bIn,
   input  logic [7:0] flagsIn,
   output logic [7:0] rfAddr,
   input  logic [7:0] rfRdData,
   output logic       rfWe,
   output logic [7:0] rfWrData,
   output logic       flagsWe,
   output logic [7:0] flagsOut,
   output logic [4:0] aluMode,
   output logic [7:0] aluA,
   output logic [7:0] aluB,
   output logic [7:0] aluFlags,
   input  logic [7:0] aluOut,
   input  logic [7:0] aluOutFlags,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] OP_SINGLE = 2'd0;
   localparam logic [1:0] OP_INCW   = 2'd1;
   localparam logic [1:0] OP_DECW   = 2'd2;
   localparam logic [1:0] OP_DA     = 2'd3;

   localparam logic [4:0] ALU2_TCM  = 5'h06;
   localparam logic [4:0] ALU2_TM   = 5'h07;
   localparam logic [4:0] ALU2_CP   = 5'h08;
   localparam logic [4:0] ALU1_INC  = 5'h10;
   localparam logic [4:0] ALU1_DEC  = 5'h11;
   localparam logic [4:0] ALU1_DA   = 5'h12;
   localparam logic [4:0] ALU1_DA_H = 5'h13;
   localparam logic [4:0] ALU1_INCW = 5'h14;
   localparam logic [4:0] ALU1_DECW = 5'h15;

   typedef enum logic [1:0] {IDLE, STEP1, STEP2} state_t;

   state_t     state_q;
   logic [1:0] op_q;
   logic [4:0] mode_q;
   logic [7:0] addr_q;
   logic [7:0] b_q;
   logic [7:0] flags_q;
   logic [7:0] temp_q;
   logic [7:0] tFlags_q;
   logic       done_q;
   logic       noWb;

`ifdef ALU_SEQ_CP_NOWB_EN
   assign noWb = (mode_q == ALU2_CP) || (mode_q == ALU2_TM) || (mode_q == ALU2_TCM);
`else
   assign noWb = 1'b0;
`endif

   assign busy = (state_q != IDLE);
   assign done = done_q;

   // Command latch and step sequencing; temp/tFlags carry the first-half result into STEP2.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= 2'd0;
         mode_q   <= 5'd0;
         addr_q   <= 8'd0;
         b_q      <= 8'd0;
         flags_q  <= 8'd0;
         temp_q   <= 8'd0;
         tFlags_q <= 8'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  mode_q  <= mode;
                  addr_q  <= addr;
                  b_q     <= bIn;
                  flags_q <= flagsIn;
                  state_q <= STEP1;
               end
            end
            STEP1: begin
               temp_q   <= aluOut;
               tFlags_q <= aluOutFlags;
               if (op_q == OP_SINGLE) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= STEP2;
               end
            end
            STEP2: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Word ops touch the odd (low) byte first, then the even (high) byte of the pair.
   always_comb begin
      rfAddr = 8'd0;
      case (state_q)
         STEP1:   rfAddr = ((op_q == OP_INCW) || (op_q == OP_DECW)) ? (addr_q | 8'h01) : addr_q;
         STEP2:   rfAddr = (op_q == OP_DA) ? addr_q : (addr_q & 8'hFE);
         default: rfAddr = 8'd0;
      endcase
   end

   // ALU operand steering; DA's upper half works on the adjusted low half, not the register.
   always_comb begin
      aluMode  = 5'd0;
      aluA     = 8'd0;
      aluB     = 8'd0;
      aluFlags = 8'd0;
      case (state_q)
         STEP1: begin
            aluA     = rfRdData;
            aluFlags = flags_q;
            case (op_q)
               OP_SINGLE: begin
                  aluMode = mode_q;
                  aluB    = b_q;
               end
               OP_INCW: aluMode = ALU1_INC;
               OP_DECW: aluMode = ALU1_DEC;
               default: aluMode = ALU1_DA;
            endcase
         end
         STEP2: begin
            if (op_q == OP_DA) begin
               aluMode  = ALU1_DA_H;
               aluA     = temp_q;
               aluFlags = tFlags_q;
            end else begin
               aluMode  = (op_q == OP_INCW) ? ALU1_INCW : ALU1_DECW;
               aluA     = rfRdData;
               aluB     = temp_q;
               aluFlags = flags_q;
            end
         end
         default: ;
      endcase
   end

   // Write-back: flags commit only on the final step of a command.
   always_comb begin
      rfWe     = 1'b0;
      rfWrData = 8'd0;
      flagsWe  = 1'b0;
      flagsOut = 8'd0;
      case (state_q)
         STEP1: begin
            rfWrData = aluOut;
            if (op_q == OP_SINGLE) begin
               rfWe     = !noWb;
               flagsWe  = 1'b1;
               flagsOut = aluOutFlags;
            end else if (op_q != OP_DA) begin
               rfWe = 1'b1;
            end
         end
         STEP2: begin
            rfWe     = 1'b1;
            flagsWe  = 1'b1;
            flagsOut = aluOutFlags;
            rfWrData = (op_q == OP_DA) ? {aluOut[7:4], temp_q[3:0]} : aluOut;
         end
         default: ;
      endcase
   end

endmodule
